scr1_dmem_router_mp: RTL and testbench

Parametrised multi-port data memory router between the SCR1 core DMEM interface and `PORT_NUM` downstream ports, with up to `OUTSTANDING` pipelined transactions in flight. It succeeds the fixed three-port router. Each port has its own address mask/pattern, decoded with a fixed priority. Ordering is preserved by allowing in-flight transactions to only one port at a time. It sits in the top level between the core DMEM bus and TCM, timer, and AHB/AXI bridges.

---
 rtl/scr1_dmem_rt_pkg.sv | 44 ++++
 rtl/scr1_dmem_rt_decoder.sv | 43 ++++
 rtl/scr1_dmem_router_mp.sv | 139 +++++++++++++
 tb/tb_scr1_dmem_router_mp.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_dmem_rt_pkg.sv
// -----------------------------------------------------------------------------
// scr1_dmem_rt_pkg
// Shared types and constants for the multi-port DMEM router:
//   - DMEM bus widths and the SCR1 memory command/width/response enums
//   - router limits (max ports, max outstanding transactions)
//   - port-index type wide enough for PORT_NUM real ports plus the
//     decode-error pseudo-port (sized for the maximum port count)
// -----------------------------------------------------------------------------
package scr1_dmem_rt_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    localparam int SCR1_DMEM_RT_MAX_PORTS = 8;
    localparam int SCR1_DMEM_RT_MAX_OUTST = 4;

    // Index of a port; one extra code is reserved for the pseudo-port.
    localparam int SCR1_DMEM_RT_IDX_W = $clog2(SCR1_DMEM_RT_MAX_PORTS + 1);
    typedef logic [SCR1_DMEM_RT_IDX_W-1:0] type_scr1_dmem_rt_idx_t;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    // A response completes a transaction whether it is OK or an error.
    function automatic logic scr1_dmem_rt_resp_done(input type_scr1_mem_resp_e r);
        return (r == SCR1_MEM_RESP_RDY_OK) || (r == SCR1_MEM_RESP_RDY_ER);
    endfunction

endpackage

// File: rtl/scr1_dmem_rt_decoder.sv
// -----------------------------------------------------------------------------
// scr1_dmem_rt_decoder
// Combinational fixed-priority address decoder.
//   addr   in  : request address
//   sel    out : selected port index (lowest matching index >= 1, else 0)
//   decerr out : no port claims the address (only with SCR1_DMEM_RT_DECERR_EN)
// Configuration macro: SCR1_DMEM_RT_DECERR_EN. When defined, port 0 is no
// longer a catch-all; it must match its own mask/pattern, and an unmatched
// address selects the pseudo-port index PORT_NUM with decerr set.
// -----------------------------------------------------------------------------
module scr1_dmem_rt_decoder
    import scr1_dmem_rt_pkg::*;
#(
    parameter int PORT_NUM = 3,
    parameter logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_MASK =
        {32'hFFFF0000, 32'hFFFF0000, 32'h00000000},
    parameter logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_PATTERN =
        {32'h00020000, 32'h00010000, 32'h00000000}
) (
    input  logic [SCR1_DMEM_AWIDTH-1:0] addr,
    output type_scr1_dmem_rt_idx_t      sel,
    output logic                        decerr
);

    always_comb begin
        sel    = '0;
        decerr = 1'b0;
`ifdef SCR1_DMEM_RT_DECERR_EN
        if ((addr & PORT_ADDR_MASK[0]) != PORT_ADDR_PATTERN[0]) begin
            sel    = type_scr1_dmem_rt_idx_t'(PORT_NUM);
            decerr = 1'b1;
        end
`endif
        // Walk downwards so the lowest matching index wins.
        for (int i = PORT_NUM - 1; i >= 1; i--) begin
            if ((addr & PORT_ADDR_MASK[i]) == PORT_ADDR_PATTERN[i]) begin
                sel    = type_scr1_dmem_rt_idx_t'(i);
                decerr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scr1_dmem_router_mp.sv
// -----------------------------------------------------------------------------
// scr1_dmem_router_mp
// Routes the core DMEM bus to PORT_NUM downstream ports with up to
// OUTSTANDING pipelined transactions. All in-flight transactions belong to a
// single port (cur_port), which keeps responses in order without tags.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   dmem_req/cmd/width/addr/wdata : core request side (in)
//   dmem_req_ack, dmem_rdata, dmem_resp : core handshake/response (out)
//   port_req [PORT_NUM]         : one-hot request to the decoded port (out)
//   port_cmd/width/addr/wdata   : broadcast copies of the core fields (out)
//   port_req_ack, port_rdata, port_resp : per-port handshake/response (in)
// Handshake: a request transfers on a cycle with dmem_req & dmem_req_ack;
// a response transfers on any cycle dmem_resp is RDY_OK or RDY_ER.
// Configuration macro: SCR1_DMEM_RT_DECERR_EN (see scr1_dmem_rt_decoder);
// the pseudo-port acknowledges at once and answers RDY_ER with zero data.
// -----------------------------------------------------------------------------
module scr1_dmem_router_mp
    import scr1_dmem_rt_pkg::*;
#(
    parameter int PORT_NUM    = 3,
    parameter int OUTSTANDING = 2,
    parameter logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_MASK =
        {32'hFFFF0000, 32'hFFFF0000, 32'h00000000},
    parameter logic [PORT_NUM-1:0][SCR1_DMEM_AWIDTH-1:0] PORT_ADDR_PATTERN =
        {32'h00020000, 32'h00010000, 32'h00000000}
) (
    input  logic                                       clk,
    input  logic                                       rst,
    output logic                                       dmem_req_ack,
    input  logic                                       dmem_req,
    input  type_scr1_mem_cmd_e                         dmem_cmd,
    input  type_scr1_mem_width_e                       dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]                dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0]                dmem_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0]                dmem_rdata,
    output type_scr1_mem_resp_e                        dmem_resp,
    input  logic [PORT_NUM-1:0]                        port_req_ack,
    output logic [PORT_NUM-1:0]                        port_req,
    output type_scr1_mem_cmd_e                         port_cmd,
    output type_scr1_mem_width_e                       port_width,
    output logic [SCR1_DMEM_AWIDTH-1:0]                port_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0]                port_wdata,
    input  logic [PORT_NUM-1:0][SCR1_DMEM_DWIDTH-1:0]  port_rdata,
    input  type_scr1_mem_resp_e [PORT_NUM-1:0]         port_resp
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [CW-1:0] OUTST_C = CW'(OUTSTANDING);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam type_scr1_dmem_rt_idx_t PSEUDO_C = type_scr1_dmem_rt_idx_t'(PORT_NUM);

    initial begin
        if (PORT_NUM < 2 || PORT_NUM > SCR1_DMEM_RT_MAX_PORTS)
            $fatal(1, "scr1_dmem_router_mp: PORT_NUM out of range 2..8");
        if (OUTSTANDING < 1 || OUTSTANDING > SCR1_DMEM_RT_MAX_OUTST)
            $fatal(1, "scr1_dmem_router_mp: OUTSTANDING out of range 1..4");
    end

    type_scr1_dmem_rt_idx_t sel;
    logic                   decerr;
    type_scr1_dmem_rt_idx_t cur_port;
    logic [CW-1:0]          cnt;

    type_scr1_mem_resp_e         cur_resp;
    logic [SCR1_DMEM_DWIDTH-1:0] cur_rdata;
    logic                        sel_ack;
    logic                        pop;
    logic                        push;
    logic                        can_issue;

    scr1_dmem_rt_decoder #(
        .PORT_NUM          (PORT_NUM),
        .PORT_ADDR_MASK    (PORT_ADDR_MASK),
        .PORT_ADDR_PATTERN (PORT_ADDR_PATTERN)
    ) i_decoder (
        .addr   (dmem_addr),
        .sel    (sel),
        .decerr (decerr)
    );

    always_comb begin
        cur_resp  = SCR1_MEM_RESP_NOTRDY;
        cur_rdata = '0;
        if (cnt != '0) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (cur_port == type_scr1_dmem_rt_idx_t'(i)) begin
                    cur_resp  = port_resp[i];
                    cur_rdata = port_rdata[i];
                end
            end
            // Pseudo-port (only reachable with decode errors enabled).
            if (cur_port == PSEUDO_C) begin
                cur_resp = SCR1_MEM_RESP_RDY_ER;
            end
        end

        sel_ack = decerr;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (sel == type_scr1_dmem_rt_idx_t'(i)) sel_ack = port_req_ack[i];
        end

        pop = (cnt != '0) & scr1_dmem_rt_resp_done(cur_resp);

        // Same port: issue while there is room or a slot frees this cycle.
        // Other port: only once the last outstanding transaction completes,
        // which may be the very cycle it pops.
        can_issue = (cnt == '0)
                  | (pop & (cnt == ONE_C))
                  | ((sel == cur_port) & ((cnt < OUTST_C) | pop));

        dmem_req_ack = dmem_req & sel_ack & can_issue;
        push         = dmem_req_ack;

        port_req = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            port_req[i] = dmem_req & can_issue & (sel == type_scr1_dmem_rt_idx_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cur_port <= '0;
        end else begin
            if (push & ~pop) cnt <= cnt + ONE_C;
            else if (pop & ~push) cnt <= cnt - ONE_C;
            if (push) cur_port <= sel;
        end
    end

    assign dmem_resp  = cur_resp;
    assign dmem_rdata = cur_rdata;
    assign port_cmd   = dmem_cmd;
    assign port_width = dmem_width;
    assign port_addr  = dmem_addr;
    assign port_wdata = dmem_wdata;

endmodule

// File: tb/tb_scr1_dmem_router_mp.sv
module tb_scr1_dmem_router_mp;
    import scr1_dmem_rt_pkg::*;

    localparam int PN  = 3;
    localparam int OUT = 2;
`ifdef SCR1_DMEM_RT_DECERR_EN
    localparam logic [31:0] MASK0 = 32'hFFFF0000;
`else
    localparam logic [31:0] MASK0 = 32'h00000000;
`endif
    localparam logic [PN-1:0][31:0] MASK = {32'hFFFF0000, 32'hFFFF0000, MASK0};
    localparam logic [PN-1:0][31:0] PAT  = {32'h00020000, 32'h00010000, 32'h00000000};

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                      dmem_req_ack;
    logic                      dmem_req = 1'b0;
    type_scr1_mem_cmd_e        dmem_cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e      dmem_width = SCR1_MEM_WIDTH_WORD;
    logic [31:0]               dmem_addr = '0;
    logic [31:0]               dmem_wdata = '0;
    logic [31:0]               dmem_rdata;
    type_scr1_mem_resp_e       dmem_resp;
    logic [PN-1:0]             port_req_ack = '0;
    logic [PN-1:0]             port_req;
    type_scr1_mem_cmd_e        port_cmd;
    type_scr1_mem_width_e      port_width;
    logic [31:0]               port_addr;
    logic [31:0]               port_wdata;
    logic [PN-1:0][31:0]       port_rdata = '0;
    type_scr1_mem_resp_e [PN-1:0] port_resp = {PN{SCR1_MEM_RESP_NOTRDY}};

    int n_vec = 0;
    int n_err = 0;

    scr1_dmem_router_mp #(
        .PORT_NUM(PN), .OUTSTANDING(OUT),
        .PORT_ADDR_MASK(MASK), .PORT_ADDR_PATTERN(PAT)
    ) dut (
        .clk(clk), .rst(rst),
        .dmem_req_ack(dmem_req_ack), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .port_req_ack(port_req_ack), .port_req(port_req), .port_cmd(port_cmd),
        .port_width(port_width), .port_addr(port_addr), .port_wdata(port_wdata),
        .port_rdata(port_rdata), .port_resp(port_resp)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        dmem_req     = 1'b0;
        port_req_ack = '0;
        for (int i = 0; i < PN; i++) port_resp[i] = SCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [PN-1:0] ack);
        dmem_req     = 1'b1;
        dmem_addr    = a;
        dmem_cmd     = SCR1_MEM_CMD_RD;
        dmem_width   = SCR1_MEM_WIDTH_WORD;
        port_req_ack = ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // reference decode, straight from the address map rules
    function automatic int model_decode(input logic [31:0] a);
        for (int i = 1; i < PN; i++)
            if ((a & MASK[i]) == PAT[i]) return i;
`ifdef SCR1_DMEM_RT_DECERR_EN
        if ((a & MASK[0]) != PAT[0]) return PN;
`endif
        return 0;
    endfunction

    task automatic test_reset();
        do_reset();
        port_req_ack = '1;
        for (int i = 0; i < PN; i++) port_resp[i] = SCR1_MEM_RESP_RDY_OK;
        port_rdata = {PN{32'hA5A5A5A5}};
        #1;
        n_vec++; if (int'(dut.cnt) != 0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt); end
        n_vec++; if (dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin n_err++; $display("FAIL reset_resp: got %0d want 0", dmem_resp); end
        n_vec++; if (dmem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", dmem_rdata); end
        n_vec++; if (dmem_req_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", dmem_req_ack); end
        n_vec++; if (port_req !== 3'b000) begin n_err++; $display("FAIL reset_port_req: got %b want 000", port_req); end
        drive_idle();
        port_rdata = '0;
    endtask

    task automatic test_single_read();
        do_reset();
        drive_req(32'h00010004, 3'b010);
        #1;
        n_vec++; if (port_req !== 3'b010) begin n_err++; $display("FAIL single_port_req: got %b want 010", port_req); end
        n_vec++; if (dmem_req_ack !== 1'b1) begin n_err++; $display("FAIL single_ack: got %b want 1", dmem_req_ack); end
        n_vec++; if (port_addr !== 32'h00010004) begin n_err++; $display("FAIL single_addr: got %h want 00010004", port_addr); end
        tick();
        drive_idle();
        #1;
        n_vec++; if (int'(dut.cnt) != 1) begin n_err++; $display("FAIL single_cnt1: got %0d want 1", dut.cnt); end
        n_vec++; if (dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin n_err++; $display("FAIL single_wait: got %0d want 0", dmem_resp); end
        tick();
        port_resp[1]  = SCR1_MEM_RESP_RDY_OK;
        port_rdata[1] = 32'hDEADBEEF;
        #1;
        n_vec++; if (dmem_resp !== SCR1_MEM_RESP_RDY_OK) begin n_err++; $display("FAIL single_resp: got %0d want 1", dmem_resp); end
        n_vec++; if (dmem_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata: got %h want deadbeef", dmem_rdata); end
        tick();
        drive_idle();
        #1;
        n_vec++; if (int'(dut.cnt) != 0) begin n_err++; $display("FAIL single_cnt0: got %0d want 0", dut.cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // acks every cycle, response one cycle after each accept
        for (int k = 0; k < 3; k++) begin
            drive_req(32'h00020000, 3'b100);
            port_resp[2] = (k == 0) ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
            #1;
            n_vec++; if (dmem_req_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack%0d: got %b want 1", k, dmem_req_ack); end
            tick();
        end
        dmem_req = 1'b0;
        port_resp[2] = SCR1_MEM_RESP_RDY_OK;
        tick();
        drive_idle();
        #1;
        n_vec++; if (int'(dut.cnt) != 0) begin n_err++; $display("FAIL b2b_drain: got %0d want 0", dut.cnt); end
        // responses held off: third request waits for the first response
        for (int k = 0; k < 4; k++) begin
            drive_req(32'h00020000, 3'b100);
            #1;
            n_vec++;
            if (dmem_req_ack !== ((k < 2) ? 1'b1 : 1'b0) || port_req !== ((k < 2) ? 3'b100 : 3'b000)) begin
                n_err++; $display("FAIL stall_%0d: ack=%b port_req=%b want ack=%b", k, dmem_req_ack, port_req, k < 2);
            end
            tick();
        end
        port_resp[2] = SCR1_MEM_RESP_RDY_OK;
        #1;
        n_vec++; if (dmem_req_ack !== 1'b1 || port_req !== 3'b100) begin n_err++; $display("FAIL stall_release: ack=%b port_req=%b want 1/100", dmem_req_ack, port_req); end
        tick();
        n_vec++; if (int'(dut.cnt) != 2) begin n_err++; $display("FAIL stall_full: got %0d want 2", dut.cnt); end
        dmem_req = 1'b0;
        tick();
        tick();
        drive_idle();
        #1;
        n_vec++; if (int'(dut.cnt) != 0) begin n_err++; $display("FAIL stall_drain: got %0d want 0", dut.cnt); end
    endtask

    task automatic test_port_switch();
        do_reset();
        drive_req(32'h00010000, 3'b010);
        tick();
        drive_req(32'h00000100, 3'b001);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++; if (port_req !== 3'b000 || dmem_req_ack !== 1'b0) begin n_err++; $display("FAIL switch_hold%0d: port_req=%b ack=%b want 000/0", k, port_req, dmem_req_ack); end
            tick();
        end
        port_resp[1]  = SCR1_MEM_RESP_RDY_OK;
        port_rdata[1] = 32'h11112222;
        #1;
        n_vec++; if (port_req !== 3'b001 || dmem_req_ack !== 1'b1) begin n_err++; $display("FAIL switch_issue: port_req=%b ack=%b want 001/1", port_req, dmem_req_ack); end
        n_vec++; if (dmem_rdata !== 32'h11112222) begin n_err++; $display("FAIL switch_rdata: got %h want 11112222", dmem_rdata); end
        tick();
        drive_idle();
        port_resp[1]  = SCR1_MEM_RESP_RDY_OK;
        port_resp[0]  = SCR1_MEM_RESP_RDY_OK;
        port_rdata[0] = 32'h33334444;
        #1;
        n_vec++; if (dmem_rdata !== 32'h33334444) begin n_err++; $display("FAIL switch_owner: got %h want 33334444", dmem_rdata); end
        tick();
        drive_idle();
        #1;
        n_vec++; if (int'(dut.cnt) != 0) begin n_err++; $display("FAIL switch_cnt: got %0d want 0", dut.cnt); end
    endtask

    task automatic test_error_resp();
        do_reset();
        drive_req(32'h00020010, 3'b100);
        tick();
        drive_req(32'h00020020, 3'b100);
        tick();
        drive_idle();
        port_resp[2] = SCR1_MEM_RESP_RDY_ER;
        #1;
        n_vec++; if (dmem_resp !== SCR1_MEM_RESP_RDY_ER) begin n_err++; $display("FAIL err_resp: got %0d want 2", dmem_resp); end
        tick();
        port_resp[2]  = SCR1_MEM_RESP_NOTRDY;
        #1;
        n_vec++; if (int'(dut.cnt) != 1) begin n_err++; $display("FAIL err_cnt: got %0d want 1", dut.cnt); end
        port_resp[2]  = SCR1_MEM_RESP_RDY_OK;
        port_rdata[2] = 32'h0BADF00D;
        #1;
        n_vec++; if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || dmem_rdata !== 32'h0BADF00D) begin n_err++; $display("FAIL err_second: resp=%0d rdata=%h want 1/0badf00d", dmem_resp, dmem_rdata); end
        tick();
        drive_idle();
        #1;
        n_vec++; if (int'(dut.cnt) != 0) begin n_err++; $display("FAIL err_cnt0: got %0d want 0", dut.cnt); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        drive_req(32'h00010000, 3'b010);
        tick();
        tick();
        drive_idle();
        #1;
        n_vec++; if (int'(dut.cnt) != 2) begin n_err++; $display("FAIL rstmid_pre: got %0d want 2", dut.cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        port_resp[1]  = SCR1_MEM_RESP_RDY_OK;
        port_rdata[1] = 32'hFFFFFFFF;
        #1;
        n_vec++; if (dmem_resp !== SCR1_MEM_RESP_NOTRDY || dmem_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_stray: resp=%0d rdata=%h want 0/0", dmem_resp, dmem_rdata); end
        tick();
        drive_idle();
        #1;
        n_vec++; if (int'(dut.cnt) != 0) begin n_err++; $display("FAIL rstmid_cnt: got %0d want 0", dut.cnt); end
    endtask

`ifdef SCR1_DMEM_RT_DECERR_EN
    task automatic test_decerr();
        do_reset();
        drive_req(32'h80000000, 3'b000);
        #1;
        n_vec++; if (dmem_req_ack !== 1'b1 || port_req !== 3'b000) begin n_err++; $display("FAIL decerr_ack: ack=%b port_req=%b want 1/000", dmem_req_ack, port_req); end
        tick();
        drive_idle();
        port_rdata = {PN{32'h5A5A5A5A}};
        #1;
        n_vec++; if (dmem_resp !== SCR1_MEM_RESP_RDY_ER || dmem_rdata !== 32'h0) begin n_err++; $display("FAIL decerr_resp: resp=%0d rdata=%h want 2/0", dmem_resp, dmem_rdata); end
        tick();
        port_rdata = '0;
        #1;
        n_vec++; if (int'(dut.cnt) != 0) begin n_err++; $display("FAIL decerr_cnt: got %0d want 0", dut.cnt); end
    endtask
`endif

    // randomized traffic against a queue-based reference model
    task automatic test_random();
        int          mq[$];
        int          msel;
        int          cur;
        int          r;
        logic        mpop;
        logic        allow;
        logic        sack;
        logic        exp_ack;
        logic [PN-1:0] exp_preq;
        type_scr1_mem_resp_e exp_resp;
        logic [31:0] exp_rdata;
        logic [31:0] bases[5];
        bases[0] = 32'h00010000; bases[1] = 32'h00020000; bases[2] = 32'h00000000;
        bases[3] = 32'h00030000; bases[4] = 32'h80000000;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            dmem_req     = ($urandom_range(0, 3) != 0);
            dmem_addr    = bases[$urandom_range(0, 4)] | {16'h0, 16'($urandom)};
            dmem_cmd     = type_scr1_mem_cmd_e'($urandom_range(0, 1));
            dmem_width   = type_scr1_mem_width_e'($urandom_range(0, 2));
            dmem_wdata   = $urandom;
            port_req_ack = PN'($urandom);
            for (int i = 0; i < PN; i++) begin
                r = $urandom_range(0, 3);
                port_resp[i]  = (r == 2) ? SCR1_MEM_RESP_RDY_OK :
                                (r == 3) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_NOTRDY;
                port_rdata[i] = $urandom;
            end
            #1;
            msel = model_decode(dmem_addr);
            cur  = (mq.size() > 0) ? mq[0] : -1;
            exp_resp  = SCR1_MEM_RESP_NOTRDY;
            exp_rdata = 32'h0;
            if (cur == PN) exp_resp = SCR1_MEM_RESP_RDY_ER;
            else if (cur >= 0) begin
                exp_resp  = port_resp[cur];
                exp_rdata = port_rdata[cur];
            end
            mpop  = (exp_resp != SCR1_MEM_RESP_NOTRDY);
            allow = (mq.size() == 0) || (mq.size() == 1 && mpop) ||
                    (msel == cur && (mq.size() < OUT || mpop));
            sack  = (msel == PN) ? 1'b1 : port_req_ack[msel];
            exp_ack  = dmem_req && allow && sack;
            exp_preq = '0;
            if (dmem_req && allow && msel < PN) exp_preq[msel] = 1'b1;

            n_vec++; if (port_req !== exp_preq) begin n_err++; $display("FAIL rnd_port_req c%0d: got %b want %b", c, port_req, exp_preq); end
            n_vec++; if (dmem_req_ack !== exp_ack) begin n_err++; $display("FAIL rnd_ack c%0d: got %b want %b", c, dmem_req_ack, exp_ack); end
            n_vec++; if (dmem_resp !== exp_resp) begin n_err++; $display("FAIL rnd_resp c%0d: got %0d want %0d", c, dmem_resp, exp_resp); end
            n_vec++; if (dmem_rdata !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, dmem_rdata, exp_rdata); end
            n_vec++; if (port_addr !== dmem_addr || port_wdata !== dmem_wdata || port_cmd !== dmem_cmd || port_width !== dmem_width) begin
                n_err++; $display("FAIL rnd_bcast c%0d: addr=%h wdata=%h want %h %h", c, port_addr, port_wdata, dmem_addr, dmem_wdata);
            end
            n_vec++; if (int'(dut.cnt) != mq.size()) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, dut.cnt, mq.size()); end

            if (mpop) void'(mq.pop_front());
            if (exp_ack) mq.push_back(msel);
            tick();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_port_switch();
        test_error_resp();
        test_reset_mid_op();
`ifdef SCR1_DMEM_RT_DECERR_EN
        test_decerr();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
